// File: rtl/point_double_add_gf2m.sv
// point_double_add_gf2m
// Affine elliptic-curve point unit over GF(2^M) for y^2+xy = x^3+a*x^2+b.
// Computes 2*P1 or P1+P2 with fixed latency (done in cycle 2M+2 after start).
// A single combinational field multiplier serves every step. The inverse is
// computed by Fermat exponentiation (d^(2^M-2)), so there is no divider.
// Optional macro PD_ADD_EN: when defined, the mode input selects point
// addition. When undefined, every request is a doubling and p2/mode are ignored.
module point_double_add_gf2m #(
  parameter int           M       = 7,
  parameter logic [M-1:0] POLY    = 7'h03,
  parameter logic [M-1:0] CURVE_A = 7'h01
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mode,
  input  logic [2*M-1:0] p1,
  input  logic [2*M-1:0] p2,
  output logic           busy,
  output logic           done,
  output logic [2*M-1:0] sum,
  output logic           inf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INV  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam int CW = $clog2(2*M);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] INV_LAST = CW'(2*M-4);
  localparam logic [CW-1:0] MC_LAM   = CW'(0);
  localparam logic [CW-1:0] MC_X3    = CW'(1);
  localparam logic [CW-1:0] MC_Y3    = CW'(2);
  localparam logic [CW-1:0] MC_FIN   = CW'(3);

  localparam logic [M-1:0] ZERO = {M{1'b0}};
  localparam logic [M-1:0] ONE  = {{(M-1){1'b0}}, 1'b1};

  // Shift-and-add multiply in GF(2^M). Each partial is reduced by POLY as it shifts.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = ZERO;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end else begin
        acc = acc;
      end
      if (sh[M-1]) begin
        sh = {sh[M-2:0], 1'b0} ^ POLY;
      end else begin
        sh = {sh[M-2:0], 1'b0};
      end
    end
    return acc;
  endfunction

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [M-1:0]  r_x1, r_y1;
  logic [M-1:0]  r_t, r_lam, r_x3, r_y3;
  logic          r_exc;
  logic          r_busy, r_done, r_inf;
  logic [2*M-1:0] r_sum;

  logic [M-1:0] w_p1x, w_p1y;
  logic         w_accept;
  logic         w_cap_inf;
  logic [M-1:0] w_cap_d;
  logic         w_add;
  logic [M-1:0] w_xs, w_ys, w_d;
  logic [M-1:0] w_ma, w_mb, w_prod, w_y3;

  assign w_p1x    = p1[M-1:0];
  assign w_p1y    = p1[2*M-1:M];
  assign w_accept = (r_state == S_IDLE) && start;

`ifdef PD_ADD_EN
  logic [M-1:0] r_x2, r_y2;
  logic         r_add;
  logic [M-1:0] w_p2x, w_p2y;
  logic         w_cap_add;

  assign w_p2x = p2[M-1:0];
  assign w_p2y = p2[2*M-1:M];
  assign w_add = r_add;
  assign w_xs  = r_x1 ^ r_x2;
  assign w_ys  = r_y1 ^ r_y2;

  // Classify the request at capture: a true add, an add that degenerates to a doubling, or infinity.
  always_comb begin
    w_cap_add = 1'b0;
    w_cap_inf = (w_p1x == ZERO);
    if (mode) begin
      if (w_p1x != w_p2x) begin
        w_cap_add = 1'b1;
        w_cap_inf = 1'b0;
      end else if (w_p1y != w_p2y) begin
        w_cap_add = 1'b0;
        w_cap_inf = 1'b1;
      end else begin
        w_cap_add = 1'b0;
        w_cap_inf = (w_p1x == ZERO);
      end
    end else begin
      w_cap_add = 1'b0;
      w_cap_inf = (w_p1x == ZERO);
    end
  end

  assign w_cap_d = w_cap_add ? (w_p1x ^ w_p2x) : w_p1x;

  // Hold the second operand and the effective add flag for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x2  <= ZERO;
      r_y2  <= ZERO;
      r_add <= 1'b0;
    end else if (w_accept) begin
      r_x2  <= w_p2x;
      r_y2  <= w_p2y;
      r_add <= w_cap_add;
    end else begin
      r_x2  <= r_x2;
      r_y2  <= r_y2;
      r_add <= r_add;
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^{mode, p2};
  assign w_add     = 1'b0;
  assign w_xs      = ZERO;
  assign w_ys      = ZERO;
  assign w_cap_inf = (w_p1x == ZERO);
  assign w_cap_d   = w_p1x;
`endif

  // The quantity to invert is x1 for a doubling and x1^x2 for a true add.
  assign w_d = w_add ? w_xs : r_x1;

  // Select multiplier operands. Even INV steps square t, odd steps multiply t by d.
  always_comb begin
    w_ma = r_t;
    w_mb = r_t;
    case (r_state)
      S_INV: begin
        w_ma = r_t;
        if (r_cnt[0]) begin
          w_mb = w_d;
        end else begin
          w_mb = r_t;
        end
      end
      S_MUL: begin
        case (r_cnt)
          MC_LAM: begin
            w_ma = w_add ? w_ys : r_y1;
            w_mb = r_t;
          end
          MC_X3: begin
            w_ma = r_lam;
            w_mb = r_lam;
          end
          MC_Y3: begin
            w_ma = w_add ? r_lam : r_x1;
            w_mb = w_add ? (r_x1 ^ r_x3) : r_x1;
          end
          MC_FIN: begin
            w_ma = r_lam ^ ONE;
            w_mb = r_x3;
          end
          default: begin
            w_ma = r_t;
            w_mb = r_t;
          end
        endcase
      end
      default: begin
        w_ma = r_t;
        w_mb = r_t;
      end
    endcase
  end

  assign w_prod = gf_mul(w_ma, w_mb);
  // For a doubling, r_y3 holds x1^2 at this point, and the last product finishes y3.
  assign w_y3   = w_add ? r_y3 : (r_y3 ^ w_prod);

  // Control FSM with the datapath registers and the registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_x1    <= ZERO;
      r_y1    <= ZERO;
      r_t     <= ZERO;
      r_lam   <= ZERO;
      r_x3    <= ZERO;
      r_y3    <= ZERO;
      r_exc   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_inf   <= 1'b0;
      r_sum   <= {(2*M){1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x1    <= w_p1x;
            r_y1    <= w_p1y;
            r_t     <= w_cap_d;
            r_exc   <= w_cap_inf;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b1;
            r_state <= S_INV;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_INV: begin
          r_t <= w_prod;
          if (r_cnt == INV_LAST) begin
            r_cnt   <= CNT_ZERO;
            r_state <= S_MUL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          case (r_cnt)
            MC_LAM: r_lam <= w_add ? w_prod : (r_x1 ^ w_prod);
            MC_X3:  r_x3  <= w_prod ^ r_lam ^ CURVE_A ^ (w_add ? w_xs : ZERO);
            MC_Y3:  r_y3  <= w_add ? (w_prod ^ r_x3 ^ r_y1) : w_prod;
            MC_FIN: begin
              r_cnt   <= CNT_ZERO;
              r_sum   <= r_exc ? {(2*M){1'b0}} : {w_y3, r_x3};
              r_inf   <= r_exc;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_OUT;
            end
            default: r_state <= S_IDLE;
          endcase
        end
        S_OUT: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign inf  = r_inf;

endmodule

// File: tb/tb_point_double_add_gf2m.sv
// Scoreboard bench for point_double_add_gf2m (M=7, x^7+x+1, a=1).
// The reference model uses textbook affine formulas, with inversion found by exhaustive search.
module tb_point_double_add_gf2m;

  localparam int LAT = 16;
  localparam logic [6:0] CA = 7'h01;
`ifdef PD_ADD_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode  = 1'b0;
  logic [13:0] p1    = 14'h0;
  logic [13:0] p2    = 14'h0;
  logic        busy, done, inf;
  logic [13:0] sum;

  point_double_add_gf2m dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .p1(p1), .p2(p2), .busy(busy), .done(done), .sum(sum), .inf(inf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] sum;
    logic        inf;
    int          scyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] m_mul(input logic [6:0] a, input logic [6:0] b);
    logic [12:0] p;
    p = 13'h0;
    for (int i = 0; i < 7; i++)
      if (b[i]) p = p ^ (13'(a) << i);
    for (int k = 12; k >= 7; k--)
      if (p[k]) p = p ^ (13'h083 << (k - 7));
    return p[6:0];
  endfunction

  function automatic logic [6:0] m_inv(input logic [6:0] d);
    for (int v = 1; v < 128; v++)
      if (m_mul(d, 7'(v)) == 7'h01) return 7'(v);
    return 7'h00;
  endfunction

  function automatic void model(input logic md, input logic [13:0] a, input logic [13:0] b,
                                output logic [13:0] s, output logic f);
    logic [6:0] x1, y1, x2, y2, lam, x3, y3;
    logic eadd;
    x1 = a[6:0]; y1 = a[13:7]; x2 = b[6:0]; y2 = b[13:7];
    eadd = ADD_EN && md;
    s = 14'h0;
    f = 1'b0;
    if (eadd && (x1 == x2)) begin
      if (y1 == y2) eadd = 1'b0;
      else begin f = 1'b1; return; end
    end
    if (!eadd) begin
      if (x1 == 7'h00) begin f = 1'b1; return; end
      lam = x1 ^ m_mul(y1, m_inv(x1));
      x3  = m_mul(lam, lam) ^ lam ^ CA;
      y3  = m_mul(x1, x1) ^ m_mul(lam ^ 7'h01, x3);
    end else begin
      lam = m_mul(y1 ^ y2, m_inv(x1 ^ x2));
      x3  = m_mul(lam, lam) ^ lam ^ x1 ^ x2 ^ CA;
      y3  = m_mul(lam, x1 ^ x3) ^ x3 ^ y1;
    end
    s = {y3, x3};
  endfunction

  // monitor: pop and compare each result when done pulses
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sum", 32'(sum), 32'(mon_e.sum));
        chk("inf", 32'(inf), 32'(mon_e.inf));
        chk("latency", 32'(cyc - mon_e.scyc), 32'(LAT));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic issue(input logic md, input logic [13:0] a, input logic [13:0] b,
                       input logic [13:0] es, input logic ei);
    exp_t e;
    @(negedge clk);
    start = 1'b1; mode = md; p1 = a; p2 = b;
    e.sum = es; e.inf = ei; e.scyc = cyc;
    sb.push_back(e);
    n_vec++;
    @(negedge clk);
    start = 1'b0; mode = 1'($urandom); p1 = 14'($urandom); p2 = 14'($urandom);
    chk("busy_cycle1", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("op_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_model(input logic md, input logic [13:0] a, input logic [13:0] b);
    logic [13:0] es;
    logic ei;
    model(md, a, b, es, ei);
    issue(md, a, b, es, ei);
  endtask

  initial begin
    exp_t e;
    logic [13:0] a, b;
    logic md;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_inf",  32'(inf),  32'd0);
    rst_n = 1'b1;

    // directed vectors with hand-derived results
    issue(1'b0, 14'h0001, 14'h0000, 14'h0081, 1'b0); wait_idle();
    issue(1'b0, 14'h0081, 14'h0000, 14'h0001, 1'b0); wait_idle();
    issue(1'b0, 14'h0080, 14'h0000, 14'h0000, 1'b1); wait_idle();
    issue(1'b1, 14'h0001, 14'h0080, ADD_EN ? 14'h0080 : 14'h0081, 1'b0); wait_idle();
    issue(1'b1, 14'h0001, 14'h0081, ADD_EN ? 14'h0000 : 14'h0081, ADD_EN); wait_idle();
    issue(1'b1, 14'h0081, 14'h0081, 14'h0001, 1'b0); wait_idle();

    // start pulsed in cycle 5 of an operation must be ignored
    issue(1'b0, 14'h0001, 14'h0000, 14'h0081, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; mode = 1'b0; p1 = 14'h0080;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // start held through the done cycle: accepted only in the following cycle
    issue(1'b0, 14'h0081, 14'h0000, 14'h0001, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    start = 1'b1; mode = 1'b0; p1 = 14'h0001;
    e.sum = 14'h0081; e.inf = 1'b0; e.scyc = cyc + 1;
    sb.push_back(e);
    n_vec++;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_btb", 32'(busy), 32'd1);
    wait_idle();

    // reset in the middle of an operation
    issue(1'b0, 14'h0001, 14'h0000, 14'h0081, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum",  32'(sum),  32'd0);
    chk("midrst_inf",  32'(inf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("idle_after_rst", 32'(busy), 32'd0);

    // randomized vectors, biased toward the exceptional cases
    for (int n = 0; n < 40; n++) begin
      md = 1'($urandom_range(0, 1));
      a  = 14'($urandom);
      b  = 14'($urandom);
      case ($urandom_range(0, 7))
        0: a[6:0] = 7'h00;
        1: b[6:0] = a[6:0];
        2: b = a;
        default: b = b;
      endcase
      run_model(md, a, b);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 10)) @(negedge clk);
        start = 1'b1; mode = 1'($urandom); p1 = 14'($urandom); p2 = 14'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
